// File: rtl/cp0_issue_ctrl_pkg.sv
// Types and helpers for the CP0 issue controller.
package cp0_issue_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StWb,
        StHazard
    } cp0_issue_state_t;

    // The counter must be at least 1 bit wide even when no hazard stall is configured.
    function automatic int unsigned hazard_cnt_w(input int unsigned cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/cpu_defs.sv
// Core-wide shared types: ROB tags, exception descriptors, 32-bit data.
package cpu_defs;

    typedef logic [31:0] uint32_t;

    localparam int unsigned RobIdxW = 5;  // 4 index bits plus wrap bit

    typedef logic [RobIdxW-1:0] rob_index_t;

    typedef struct packed {
        logic       valid;
        logic       eret;
        logic [4:0] code;
    } exception_t;

endpackage

// File: rtl/cp0_hazard_timer.sv
// Post-MTC0 hazard counter: load with HAZARD_CYCLES, count down to zero, flag the final cycle.
module cp0_hazard_timer
    import cp0_issue_ctrl_pkg::*;
#(
    parameter int unsigned HAZARD_CYCLES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic load,
    output logic done
);

    localparam int unsigned W = hazard_cnt_w(HAZARD_CYCLES);
    localparam logic [W-1:0] LoadVal = W'(HAZARD_CYCLES);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = LoadVal;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == W'(1));

endmodule

// File: rtl/cp0_issue_ctrl.sv
// CP0 issue controller: issues CP0 ops only at the ROB head, broadcasts on the CDB,
// and stalls after MTC0. Optional perf counters under CP0_ISSUE_PERF_EN.
module cp0_issue_ctrl
    import cpu_defs::*;
    import cp0_issue_ctrl_pkg::*;
#(
    parameter int unsigned HAZARD_CYCLES = 2,
    parameter int unsigned CNT_W         = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              rs_data_ready,
    input  rob_index_t        rs_data_reorder,
    input  logic              rs_is_mtc0,
    input  exception_t        rs_ex,
    output logic              rs_data_ack,
    input  rob_index_t        rob_head,
    input  logic              rob_head_valid,
    input  uint32_t           cp0_rdata,
    output logic              cdb_req_valid,
    output rob_index_t        cdb_req_reorder,
    output uint32_t           cdb_req_value,
    output exception_t        cdb_req_ex,
    input  logic              cdb_grant
`ifdef CP0_ISSUE_PERF_EN
    ,
    output logic [CNT_W-1:0]  perf_issued,
    output logic [CNT_W-1:0]  perf_stall
`endif
);

    cp0_issue_state_t state_q, state_d;
    rob_index_t       reorder_q, reorder_d;
    uint32_t          value_q, value_d;
    exception_t       ex_q, ex_d;
    logic             last_mtc0_q, last_mtc0_d;
    logic             timer_load, timer_clear, timer_done;

    // Gated by rst_n so the RS never sees an issue while the controller is held in reset.
    assign rs_data_ack = rst_n && (state_q == StIdle) && rs_data_ready && rob_head_valid &&
                         (rs_data_reorder == rob_head) && !flush;

    always_comb begin
        state_d     = state_q;
        reorder_d   = reorder_q;
        value_d     = value_q;
        ex_d        = ex_q;
        last_mtc0_d = last_mtc0_q;
        timer_load  = 1'b0;
        timer_clear = 1'b0;
        if (flush) begin
            state_d     = StIdle;
            timer_clear = 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (rs_data_ack) begin
                        state_d     = StWb;
                        reorder_d   = rs_data_reorder;
                        value_d     = (rs_is_mtc0 || rs_ex.eret) ? '0 : cp0_rdata;
                        ex_d        = rs_ex;
                        last_mtc0_d = rs_is_mtc0;
                    end
                end
                StWb: begin
                    if (cdb_grant) begin
                        if (last_mtc0_q && (HAZARD_CYCLES != 0)) begin
                            state_d    = StHazard;
                            timer_load = 1'b1;
                        end else begin
                            state_d = StIdle;
                        end
                    end
                end
                StHazard: begin
                    if (timer_done) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            reorder_q   <= '0;
            value_q     <= '0;
            ex_q        <= '0;
            last_mtc0_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            reorder_q   <= reorder_d;
            value_q     <= value_d;
            ex_q        <= ex_d;
            last_mtc0_q <= last_mtc0_d;
        end
    end

    cp0_hazard_timer #(
        .HAZARD_CYCLES(HAZARD_CYCLES)
    ) u_hazard_timer (
        .clk  (clk),
        .rst_n(rst_n),
        .clear(timer_clear),
        .load (timer_load),
        .done (timer_done)
    );

    assign cdb_req_valid   = (state_q == StWb);
    assign cdb_req_reorder = reorder_q;
    assign cdb_req_value   = value_q;
    assign cdb_req_ex      = ex_q;

`ifdef CP0_ISSUE_PERF_EN
    logic [CNT_W-1:0] issued_q, issued_d;
    logic [CNT_W-1:0] stall_q, stall_d;

    always_comb begin
        issued_d = issued_q;
        stall_d  = stall_q;
        if (rs_data_ack) begin
            issued_d = issued_q + 1'b1;
        end
        if ((state_q == StHazard) || ((state_q == StIdle) && rs_data_ready && !rs_data_ack)) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issued_q <= '0;
            stall_q  <= '0;
        end else begin
            issued_q <= issued_d;
            stall_q  <= stall_d;
        end
    end

    assign perf_issued = issued_q;
    assign perf_stall  = stall_q;
`endif

endmodule

// File: tb/tb_cp0_issue_ctrl.sv
// Directed bench for cp0_issue_ctrl (HAZARD_CYCLES=2); perf checks only with CP0_ISSUE_PERF_EN.
module tb_cp0_issue_ctrl;
    import cpu_defs::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       flush = 1'b0;
    logic       rs_data_ready = 1'b0;
    rob_index_t rs_data_reorder = '0;
    logic       rs_is_mtc0 = 1'b0;
    exception_t rs_ex = '0;
    logic       rs_data_ack;
    rob_index_t rob_head = '0;
    logic       rob_head_valid = 1'b0;
    uint32_t    cp0_rdata = '0;
    logic       cdb_req_valid;
    rob_index_t cdb_req_reorder;
    uint32_t    cdb_req_value;
    exception_t cdb_req_ex;
    logic       cdb_grant = 1'b0;
`ifdef CP0_ISSUE_PERF_EN
    logic [31:0] perf_issued;
    logic [31:0] perf_stall;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    cp0_issue_ctrl #(
        .HAZARD_CYCLES(2),
        .CNT_W        (32)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .rs_data_ready  (rs_data_ready),
        .rs_data_reorder(rs_data_reorder),
        .rs_is_mtc0     (rs_is_mtc0),
        .rs_ex          (rs_ex),
        .rs_data_ack    (rs_data_ack),
        .rob_head       (rob_head),
        .rob_head_valid (rob_head_valid),
        .cp0_rdata      (cp0_rdata),
        .cdb_req_valid  (cdb_req_valid),
        .cdb_req_reorder(cdb_req_reorder),
        .cdb_req_value  (cdb_req_value),
        .cdb_req_ex     (cdb_req_ex),
        .cdb_grant      (cdb_grant)
`ifdef CP0_ISSUE_PERF_EN
        ,
        .perf_issued    (perf_issued),
        .perf_stall     (perf_stall)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        #1 rst_n = 1'b0;
        #2;
        chk("rst_valid", 64'(cdb_req_valid), 64'd0);
        chk("rst_reorder", 64'(cdb_req_reorder), 64'd0);
        chk("rst_value", 64'(cdb_req_value), 64'd0);
        chk("rst_ex", 64'(cdb_req_ex), 64'd0);
        chk("rst_ack", 64'(rs_data_ack), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;

        // MFC0 at head
        rob_head_valid = 1'b1;
        rob_head = 5'd5;
        rs_data_reorder = 5'd5;
        rs_data_ready = 1'b1;
        cp0_rdata = 32'h1234_5678;
        #2 chk("mfc0_ack", 64'(rs_data_ack), 64'd1);
        tick();
        rs_data_ready = 1'b0;
        cp0_rdata = 32'h0;
        #2;
        chk("mfc0_valid", 64'(cdb_req_valid), 64'd1);
        chk("mfc0_reorder", 64'(cdb_req_reorder), 64'd5);
        chk("mfc0_value", 64'(cdb_req_value), 64'h1234_5678);
`ifdef CP0_ISSUE_PERF_EN
        chk("perf_issued_1", 64'(perf_issued), 64'd1);
`endif
        tick();
        #2;
        chk("mfc0_hold_valid", 64'(cdb_req_valid), 64'd1);
        chk("mfc0_hold_value", 64'(cdb_req_value), 64'h1234_5678);
        cdb_grant = 1'b1;
        tick();
        cdb_grant = 1'b0;
        #2 chk("mfc0_granted", 64'(cdb_req_valid), 64'd0);

        // Not at head for 4 cycles, then wrap-bit mismatch, then at head
        rs_data_reorder = 5'd7;
        rob_head = 5'd5;
        rs_data_ready = 1'b1;
        cp0_rdata = 32'hCAFE_F00D;
        for (int i = 0; i < 4; i++) begin
            #2 chk("nohead_ack", 64'(rs_data_ack), 64'd0);
            tick();
        end
        rob_head = 5'h17;
        #2 chk("wrapbit_ack", 64'(rs_data_ack), 64'd0);
        tick();
        rob_head = 5'd7;
        #2 chk("head_ack", 64'(rs_data_ack), 64'd1);
        tick();
        rs_data_ready = 1'b0;
        #2;
        chk("head_reorder", 64'(cdb_req_reorder), 64'd7);
        chk("head_value", 64'(cdb_req_value), 64'hCAFE_F00D);
        cdb_grant = 1'b1;
        tick();
        cdb_grant = 1'b0;

        // MTC0 then hazard stall of 2 cycles
        rs_data_reorder = 5'd8;
        rob_head = 5'd8;
        rs_is_mtc0 = 1'b1;
        rs_data_ready = 1'b1;
        cp0_rdata = 32'hDEAD_BEEF;
        #2 chk("mtc0_ack", 64'(rs_data_ack), 64'd1);
        tick();
        rs_data_ready = 1'b0;
        #2;
        chk("mtc0_valid", 64'(cdb_req_valid), 64'd1);
        chk("mtc0_value", 64'(cdb_req_value), 64'd0);
        cdb_grant = 1'b1;
        rs_data_reorder = 5'd9;
        rob_head = 5'd9;
        rs_is_mtc0 = 1'b0;
        rs_data_ready = 1'b1;
        cp0_rdata = 32'h0000_0009;
        #2 chk("mtc0_grant_ack", 64'(rs_data_ack), 64'd0);
        tick();
        cdb_grant = 1'b0;
        #2;
        chk("haz1_ack", 64'(rs_data_ack), 64'd0);
        chk("haz1_valid", 64'(cdb_req_valid), 64'd0);
        tick();
        #2 chk("haz2_ack", 64'(rs_data_ack), 64'd0);
        tick();
        #2 chk("haz_done_ack", 64'(rs_data_ack), 64'd1);
        tick();
        rs_data_ready = 1'b0;
        #2;
        chk("op9_reorder", 64'(cdb_req_reorder), 64'd9);
        chk("op9_value", 64'(cdb_req_value), 64'd9);

        // Back-to-back into ERET: no ack in grant cycle, ack next cycle
        cdb_grant = 1'b1;
        rs_data_reorder = 5'd10;
        rob_head = 5'd10;
        rs_ex = '{valid: 1'b1, eret: 1'b1, code: 5'h0d};
        cp0_rdata = 32'h0000_0055;
        rs_data_ready = 1'b1;
        #2 chk("b2b_grant_ack", 64'(rs_data_ack), 64'd0);
        tick();
        cdb_grant = 1'b0;
        #2 chk("b2b_next_ack", 64'(rs_data_ack), 64'd1);
        tick();
        rs_data_ready = 1'b0;
        rs_ex = '0;
        #2;
        chk("eret_ex", 64'(cdb_req_ex), 64'h6d);
        chk("eret_value", 64'(cdb_req_value), 64'd0);
        cdb_grant = 1'b1;
        rs_data_reorder = 5'd11;
        rob_head = 5'd11;
        cp0_rdata = 32'h0000_1111;
        rs_data_ready = 1'b1;
        tick();
        cdb_grant = 1'b0;
        #2 chk("eret_nohaz_ack", 64'(rs_data_ack), 64'd1);
        tick();
        rs_data_ready = 1'b0;
        #2 chk("op11_reorder", 64'(cdb_req_reorder), 64'd11);

        // Flush together with grant in WB
        flush = 1'b1;
        cdb_grant = 1'b1;
        rs_data_reorder = 5'd12;
        rob_head = 5'd12;
        rs_is_mtc0 = 1'b1;
        cp0_rdata = 32'h0000_0077;
        rs_data_ready = 1'b1;
        #2 chk("flush_wb_ack", 64'(rs_data_ack), 64'd0);
        tick();
        cdb_grant = 1'b0;
        #1 chk("flush_idle_ack", 64'(rs_data_ack), 64'd0);
        flush = 1'b0;
        #1;
        chk("flush_valid", 64'(cdb_req_valid), 64'd0);
        chk("post_flush_ack", 64'(rs_data_ack), 64'd1);
        tick();
        rs_data_ready = 1'b0;
        rs_is_mtc0 = 1'b0;
        #2 chk("op12_valid", 64'(cdb_req_valid), 64'd1);

        // Async reset while in HAZARD
        cdb_grant = 1'b1;
        tick();
        cdb_grant = 1'b0;
        rs_data_reorder = 5'd13;
        rob_head = 5'd13;
        rs_data_ready = 1'b1;
        #2;
        chk("hazard_ack", 64'(rs_data_ack), 64'd0);
        chk("hazard_reorder_held", 64'(cdb_req_reorder), 64'd12);
        rst_n = 1'b0;
        #1;
        chk("arst_reorder", 64'(cdb_req_reorder), 64'd0);
        chk("arst_valid", 64'(cdb_req_valid), 64'd0);
        chk("arst_ack", 64'(rs_data_ack), 64'd0);
`ifdef CP0_ISSUE_PERF_EN
        chk("arst_perf_issued", 64'(perf_issued), 64'd0);
        chk("arst_perf_stall", 64'(perf_stall), 64'd0);
`endif
        tick();
        rst_n = 1'b1;
        #2 chk("post_rst_ack", 64'(rs_data_ack), 64'd1);
        tick();
        rs_data_ready = 1'b0;
        #2 chk("post_rst_reorder", 64'(cdb_req_reorder), 64'd13);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cp0_issue_ctrl.md
Name: cp0_issue_ctrl

Overview:
- Downstream of the CP0 reservation station in the OoO core.
- Holds a ready CP0-class instruction (MFC0/MTC0/ERET) until it is the oldest uncommitted ROB entry, so CP0 side effects are non-speculative.
- On issue it acks the RS (which performs the CP0 write), latches the read data and exception, and broadcasts the result on a CDB request port.
- After any MTC0 it enforces a programmable CP0 write-hazard stall before the next issue.

Parameters:
- HAZARD_CYCLES, 2, idle cycles enforced after an MTC0 issue before the next issue (0 = none).
- CNT_W, 32, width of the optional perf counters.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  pipeline flush (branch mispredict/exception), synchronous
- rs_data_ready  in  1  CP0 RS entry valid with all operands ready
- rs_data_reorder  in  rob_index_t  ROB tag of the RS entry
- rs_is_mtc0  in  1  RS entry is MTC0
- rs_ex  in  exception_t  exception produced by the RS entry (ERET etc.)
- rs_data_ack  out  1  issue strobe to the RS; clears the entry and commits the CP0 write
- rob_head  in  rob_index_t  index of the oldest ROB entry
- rob_head_valid  in  1  ROB non-empty
- cp0_rdata  in  uint32_t  CP0 read data for the RS entry's address/sel (combinational)
- cdb_req_valid  out  1  result pending on CDB
- cdb_req_reorder  out  rob_index_t  result tag
- cdb_req_value  out  uint32_t  result value
- cdb_req_ex  out  exception_t  result exception
- cdb_grant  in  1  CDB arbiter accepts the request this cycle
- perf_issued  out  CNT_W  (optional feature only) issued op count
- perf_stall  out  CNT_W  (optional feature only) head-wait and hazard stall cycles

Behaviour:
- States:
  - IDLE: no result pending.
  - WB: result pending on CDB.
  - HAZARD: post-MTC0 stall.
- Reset (rst_n low, async):
  - State IDLE.
  - All cdb_req_* outputs 0; rs_data_ack 0.
  - Hazard counter 0; perf counters 0.
- rs_data_ack is combinational. It is high only when all of the following hold:
  - state==IDLE
  - rs_data_ready
  - rob_head_valid
  - rs_data_reorder==rob_head
  - !flush
  - It is never high in WB or HAZARD.
- On ack (IDLE):
  - Next cycle: cdb_req_valid=1, reorder=rs_data_reorder, value=cp0_rdata (0 for MTC0/ERET), ex=rs_ex.
  - State goes to WB. Issue-to-CDB latency is 1 cycle.
- WB:
  - All cdb_req_* fields are held stable while cdb_grant=0.
  - On cdb_grant with last-issued op MTC0 and HAZARD_CYCLES>0: clear valid, load counter with HAZARD_CYCLES, go to HAZARD.
  - On cdb_grant otherwise: clear valid, go to IDLE.
- HAZARD:
  - Decrement the counter each cycle.
  - When the counter is 1, go to IDLE. Exactly HAZARD_CYCLES cycles with no ack.
- flush (highest priority, any state):
  - Next state IDLE; cdb_req_valid 0; counter 0; ack suppressed that cycle.
  - A grant coinciding with a flush has no effect beyond the flush.
- Not at head (rs_data_ready=1 but tag!=rob_head): wait in IDLE, no ack.
- ROB index comparison is exact equality on the full rob_index_t, wrap bit included.
- Back-to-back: a new ack is possible in the cycle after a grant when the granted op is not MTC0 (state IDLE by then). There is no ack in the same cycle as a grant.

Optional Feature:
- Macro CP0_ISSUE_PERF_EN.
- Defined:
  - perf_issued increments on every rs_data_ack.
  - perf_stall increments each cycle in HAZARD, and each cycle in IDLE with rs_data_ready=1 and no ack.
  - Both wrap modulo 2^CNT_W and are cleared by reset only (not by flush).
- Undefined: perf ports and counters are absent. Functional behaviour is otherwise identical.

Decomposition:
- Shared package (cpu_defs): rob_index_t, exception_t, uint32_t (existing).
- Shared package, new: cp0_issue_state_t enum {IDLE, WB, HAZARD}.
- One sub-module: cp0_hazard_timer (load/decrement/done counter, width clog2(HAZARD_CYCLES+1)).

Test Plan:
- MFC0 at head: rob_head=5, rs_data_reorder=5, cp0_rdata=0x1234_5678 -> ack in same cycle; next cycle cdb_req_valid=1, reorder=5, value=0x12345678; held until grant.
- Not at head: tag=7, rob_head=5 for 4 cycles, then rob_head=7 -> no ack for 4 cycles, ack in cycle 5.
- MTC0 with HAZARD_CYCLES=2: grant at cycle t, second op ready -> ack no earlier than t+3.
- ERET: rs_ex.valid=1, eret=1 -> cdb_req_ex carries it, value 0, no hazard stall.
- flush while in WB with cdb_grant=1 -> next cycle cdb_req_valid=0, IDLE; new ack possible at once.
- Async reset asserted mid-HAZARD -> outputs 0 immediately; after release, ack is possible on first eligible cycle. With CP0_ISSUE_PERF_EN, perf_issued=0.
